// File: rtl/edge_detect_multi.sv
// edge_detect_multi: per-channel sync + debounce + edge pulses, mode-qualified events, sticky flags, saturating event counter
module edge_detect_multi #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int CNT_W       = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     din,
   input  logic [2*WIDTH-1:0]   mode,
   input  logic [WIDTH-1:0]     clr,
   input  logic                 cnt_clr,
   output logic [WIDTH-1:0]     level,
   output logic [WIDTH-1:0]     pos_edge,
   output logic [WIDTH-1:0]     neg_edge,
   output logic [WIDTH-1:0]     evt,
   output logic [WIDTH-1:0]     evt_sticky,
   output logic                 evt_any,
   output logic [CNT_W-1:0]     evt_cnt
);
   localparam int DBW = $clog2(DB_CYCLES) + 1;
   localparam int PW  = $clog2(WIDTH + 1);
   localparam int SW  = (CNT_W > PW ? CNT_W : PW) + 1;
   localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [WIDTH-1:0][DBW-1:0]         db_q, db_d;
   logic [WIDTH-1:0] level_q, level_d, pos_q, pos_d, neg_q, neg_d;
   logic [WIDTH-1:0] evt_q, evt_d, sticky_q, sticky_d, s, upd;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pop;
   logic [SW-1:0]    sum;
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], din[i]};
         s[i]       = sync_q[i][SYNC_STAGES-1];
         upd[i]     = (s[i] != level_q[i]) && (db_q[i] == DB_LAST);
         db_d[i]    = (s[i] == level_q[i] || upd[i]) ? '0 : db_q[i] + DBW'(1);
         level_d[i] = upd[i] ? s[i] : level_q[i];
         pos_d[i]   = upd[i] && s[i];
         neg_d[i]   = upd[i] && !s[i];
         evt_d[i]   = (mode[2*i] && pos_d[i]) || (mode[2*i+1] && neg_d[i]);
         pop        = pop + PW'(evt_d[i]);
      end
      // set beats clear so an event coinciding with clr is never lost
      sticky_d = (sticky_q & ~clr) | evt_d;
      sum      = (cnt_clr ? '0 : SW'(cnt_q)) + SW'(pop);
      cnt_d    = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         db_q     <= '0;
         level_q  <= '0;
         pos_q    <= '0;
         neg_q    <= '0;
         evt_q    <= '0;
         sticky_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sync_d;
         db_q     <= db_d;
         level_q  <= level_d;
         pos_q    <= pos_d;
         neg_q    <= neg_d;
         evt_q    <= evt_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end
   assign level      = level_q;
   assign pos_edge   = pos_q;
   assign neg_edge   = neg_q;
   assign evt        = evt_q;
   assign evt_sticky = sticky_q;
   assign evt_any    = |evt_q;
   assign evt_cnt    = cnt_q;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: directed + random stimulus against a behavioural model; two DUTs (8-bit and 3-bit counters)
module tb_edge_detect_multi;
   localparam int W  = 4;
   localparam int SS = 2;
   localparam int DB = 4;
   logic clk = 1'b0, rst = 1'b1, cnt_clr = 1'b0;
   logic [W-1:0] din = '0, clr = '0;
   logic [2*W-1:0] mode = '0;
   logic [W-1:0] level, pos_edge, neg_edge, evt, evt_sticky;
   logic [W-1:0] level_s, pos_s, neg_s, evt_s, sticky_s;
   logic evt_any, any_s;
   logic [7:0] evt_cnt;
   logic [2:0] cnt_s;
   int errors = 0, checks = 0;
   logic [W-1:0] m_sync [SS];
   int m_run [W];
   logic [W-1:0] m_level = '0, m_pos = '0, m_neg = '0, m_evt = '0, m_sticky = '0;
   int m_total = 0;
   always #5 clk = ~clk;
   edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
      .level(level), .pos_edge(pos_edge), .neg_edge(neg_edge), .evt(evt),
      .evt_sticky(evt_sticky), .evt_any(evt_any), .evt_cnt(evt_cnt));
   edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
      .level(level_s), .pos_edge(pos_s), .neg_edge(neg_s), .evt(evt_s),
      .evt_sticky(sticky_s), .evt_any(any_s), .evt_cnt(cnt_s));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // model: s is din delayed SS edges; level follows s after DB consecutive mismatching cycles
   task automatic model_step();
      logic [W-1:0] s;
      int pop;
      bit upd;
      if (rst) begin
         for (int k = 0; k < SS; k++) m_sync[k] = '0;
         for (int i = 0; i < W; i++) m_run[i] = 0;
         m_level = '0; m_pos = '0; m_neg = '0; m_evt = '0; m_sticky = '0; m_total = 0;
      end else begin
         s = m_sync[0];
         for (int k = 0; k < SS-1; k++) m_sync[k] = m_sync[k+1];
         m_sync[SS-1] = din;
         pop = 0;
         for (int i = 0; i < W; i++) begin
            upd = 0;
            if (s[i] != m_level[i]) begin
               m_run[i]++;
               if (m_run[i] == DB) begin
                  upd = 1; m_level[i] = s[i]; m_run[i] = 0;
               end
            end else m_run[i] = 0;
            m_pos[i] = upd && s[i];
            m_neg[i] = upd && !s[i];
            m_evt[i] = upd && (s[i] ? mode[2*i] : mode[2*i+1]);
            pop += int'(m_evt[i]);
         end
         m_sticky = (m_sticky & ~clr) | m_evt;
         m_total  = cnt_clr ? pop : m_total + pop;
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".level"}, 32'(level), 32'(m_level));
      chk({tag, ".pos_edge"}, 32'(pos_edge), 32'(m_pos));
      chk({tag, ".neg_edge"}, 32'(neg_edge), 32'(m_neg));
      chk({tag, ".evt"}, 32'(evt), 32'(m_evt));
      chk({tag, ".evt_sticky"}, 32'(evt_sticky), 32'(m_sticky));
      chk({tag, ".evt_any"}, 32'(evt_any), 32'(|m_evt));
      chk({tag, ".evt_cnt"}, 32'(evt_cnt), (m_total > 255) ? 32'd255 : 32'(m_total));
      chk({tag, ".evt_cnt3"}, 32'(cnt_s), (m_total > 7) ? 32'd7 : 32'(m_total));
   endtask
   task automatic cyc(input int n, input string tag);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check_all(tag);
      end
   endtask
   initial begin
      int first_k, npulse;
      for (int k = 0; k < SS; k++) m_sync[k] = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      cyc(3, "reset");
      chk("reset_all_zero", 32'({level, pos_edge, neg_edge, evt, evt_sticky, evt_cnt}), 32'd0);
      rst = 1'b0;
      cyc(20, "idle");
      mode = 8'b0000_0001;
      din[0] = 1'b1;
      first_k = 0; npulse = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1, "rise");
         if (pos_edge[0]) begin
            npulse++;
            if (first_k == 0) first_k = k;
         end
      end
      chk("rise_latency", 32'(first_k), 32'd6);
      chk("rise_one_pulse", 32'(npulse), 32'd1);
      chk("rise_sticky", 32'(evt_sticky[0]), 32'd1);
      chk("rise_cnt", 32'(evt_cnt), 32'd1);
      mode = 8'b0000_0101;
      din[1] = 1'b1;
      cyc(3, "glitch_hi");
      din[1] = 1'b0;
      cyc(12, "glitch_lo");
      chk("glitch_level", 32'(level[1]), 32'd0);
      chk("glitch_cnt", 32'(evt_cnt), 32'd1);
      din[1] = 1'b1;
      cyc(10, "held");
      chk("held_level", 32'(level[1]), 32'd1);
      chk("held_cnt", 32'(evt_cnt), 32'd2);
      din[2] = 1'b1;
      cyc(10, "mask_rise");
      din[2] = 1'b0;
      cyc(10, "mask_fall");
      chk("mask_cnt", 32'(evt_cnt), 32'd2);
      mode = 8'b0011_0101;
      din[2] = 1'b1;
      cyc(10, "both_rise");
      din[2] = 1'b0;
      cyc(10, "both_fall");
      chk("both_cnt", 32'(evt_cnt), 32'd4);
      mode = 8'b0101_0101;
      din = '0;
      cyc(12, "all_low");
      clr = 4'hF;
      cyc(1, "clr_all");
      clr = '0;
      din = 4'hF;
      cyc(5, "simul_wait");
      clr = 4'hF; cnt_clr = 1'b1;
      cyc(1, "simul");
      chk("simul_evt", 32'(evt), 32'hF);
      chk("simul_sticky", 32'(evt_sticky), 32'hF);
      chk("simul_cnt", 32'(evt_cnt), 32'd4);
      clr = '0; cnt_clr = 1'b0;
      cyc(4, "simul_after");
      mode = 8'hFF;
      cnt_clr = 1'b1;
      cyc(1, "sat_clr");
      cnt_clr = 1'b0;
      repeat (3) begin
         din = '0;
         cyc(8, "sat_fall");
         din = 4'hF;
         cyc(8, "sat_rise");
      end
      chk("sat_cnt3", 32'(cnt_s), 32'd7);
      chk("sat_cnt8", 32'(evt_cnt), 32'd24);
      din[0] = 1'b0;
      cyc(4, "midrst_pending");
      rst = 1'b1;
      cyc(1, "midrst");
      rst = 1'b0;
      din = 4'h0;
      npulse = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1, "midrst_after");
         if (neg_edge[0] || pos_edge[0]) npulse++;
      end
      chk("midrst_no_edge", 32'(npulse), 32'd0);
      chk("midrst_cnt", 32'(evt_cnt), 32'd0);
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
         if ($urandom_range(0, 24) == 0) mode = 8'($urandom);
         clr     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : '0;
         cnt_clr = ($urandom_range(0, 39) == 0);
         rst     = ($urandom_range(0, 149) == 0);
         cyc(1, "random");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
